// File: rtl/cvt21_cxu_pkg.sv
// Shared constants and width helpers for the CXU-L1 to CXU-L2 adapter.
//   CXU_STATUS_W / CXU_STATUS_*  : response status encoding
//   cxu_w()         : index width for an N-entry range (never below 1 bit)
//   cxu_pos()       : width that may legally be 0, clamped to 1 bit
//   cxu_cnt_w()     : width of a counter holding 0..n
//   cxu_fifo_size() : smallest power of 2 that is >= latency (minimum 1)
package cvt21_cxu_pkg;

  localparam int CXU_STATUS_W = 3;
  localparam logic [CXU_STATUS_W-1:0] CXU_STATUS_SUCCESS = 3'd0;
  localparam logic [CXU_STATUS_W-1:0] CXU_STATUS_ERROR   = 3'd1;

  function automatic int cxu_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cxu_pos(input int n);
    return (n > 0) ? n : 1;
  endfunction

  function automatic int cxu_cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  function automatic int cxu_fifo_size(input int lat);
    int s;
    s = 1;
    while (s < lat) s = s * 2;
    return s;
  endfunction

endpackage

// File: rtl/cvt21_cxu_queue.sv
// Synchronous FIFO without fall-through: a push becomes visible at head the
// cycle after it is written. Push while full and pop while empty are ignored.
//   clk, rst_n       : clock, synchronous active-low reset
//   push, push_data  : write strobe and data
//   pop              : remove the head entry
//   head             : oldest entry (registered storage, valid when !empty)
//   full, empty      : occupancy flags
module cvt21_cxu_queue
  import cvt21_cxu_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = cxu_w(DEPTH);
  localparam int CW = cxu_cnt_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  // Explicit wrap so a depth of 1 still works with a 1-bit pointer.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = ptr_inc(wr_q);
    end
    if (do_pop) rd_d = ptr_inc(rd_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cvt21_cxu.sv
// CXU-L1 fixed-latency responder in front of a CXU-L2 target. Every accepted
// L1 request is answered exactly CXU_LATENCY enabled cycles later, with the
// target's response if it is already queued, otherwise ERROR/0. Responses
// owed for missed deadlines are discarded when they finally arrive.
//   clk, rst_n, clk_en            : clock, sync active-low reset, clock enable
//   req_*                         : L1 request (no ready, never stalled)
//   resp_*                        : L1 response, from flops through one mux
//   t_req_* / t_req_ready         : L2 request to the target
//   t_resp_* / t_resp_ready       : L2 response from the target
// The target is assumed to share clk_en: handshakes only count when enabled.
module cvt21_cxu
  import cvt21_cxu_pkg::*;
#(
  parameter int CXU_N_CXUS    = 1,
  parameter int CXU_N_STATES  = 1,
  parameter int CXU_LATENCY   = 1,
  parameter int CXU_FUNC_ID_W = 10,
  parameter int CXU_DATA_W    = 32,
  parameter int CXU_INSN_W    = 0,
  parameter int CXU_FIFO_SIZE = cxu_fifo_size(CXU_LATENCY)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clk_en,
  input  logic                             req_valid,
  input  logic [cxu_w(CXU_N_CXUS)-1:0]     req_cxu,
  input  logic [cxu_w(CXU_N_STATES)-1:0]   req_state,
  input  logic [CXU_FUNC_ID_W-1:0]         req_func,
  input  logic [CXU_DATA_W-1:0]            req_data0,
  input  logic [CXU_DATA_W-1:0]            req_data1,
  output logic                             resp_valid,
  output logic [CXU_STATUS_W-1:0]          resp_status,
  output logic [CXU_DATA_W-1:0]            resp_data,
  output logic                             t_req_valid,
  input  logic                             t_req_ready,
  output logic [cxu_w(CXU_N_CXUS)-1:0]     t_req_cxu,
  output logic [cxu_w(CXU_N_STATES)-1:0]   t_req_state,
  output logic [CXU_FUNC_ID_W-1:0]         t_req_func,
  output logic [cxu_pos(CXU_INSN_W)-1:0]   t_req_insn,
  output logic [CXU_DATA_W-1:0]            t_req_data0,
  output logic [CXU_DATA_W-1:0]            t_req_data1,
  input  logic                             t_resp_valid,
  output logic                             t_resp_ready,
  input  logic [CXU_STATUS_W-1:0]          t_resp_status,
  input  logic [CXU_DATA_W-1:0]            t_resp_data
);

  localparam int CXW    = cxu_w(CXU_N_CXUS);
  localparam int STW    = cxu_w(CXU_N_STATES);
  localparam int REQ_W  = CXU_FUNC_ID_W + STW + CXW + 2 * CXU_DATA_W;
  localparam int RSP_W  = CXU_STATUS_W + CXU_DATA_W;
  localparam int OWED_W = cxu_cnt_w(2 * CXU_FIFO_SIZE);

  if (CXU_LATENCY < 1) begin : g_chk_lat
    $error("cvt21_cxu: CXU_LATENCY must be at least 1");
  end
  if (((CXU_FIFO_SIZE & (CXU_FIFO_SIZE - 1)) != 0) || (CXU_FIFO_SIZE < CXU_LATENCY)) begin : g_chk_fifo
    $error("cvt21_cxu: CXU_FIFO_SIZE must be a power of 2 and >= CXU_LATENCY");
  end

  logic             rq_full, rq_empty, rq_push, rq_pop;
  logic [REQ_W-1:0] rq_head;
  logic             rs_full, rs_empty, rs_push, rs_pop;
  logic [RSP_W-1:0] rs_head;

  logic                   accept, refused;
  logic [CXU_LATENCY-1:0] dl_valid_q, dl_valid_d, dl_refused_q, dl_refused_d;
  logic                   tap_valid, tap_refused;
  logic                   miss, tresp_hs, discard;
  logic [OWED_W-1:0]      owed_q, owed_d;

  assign accept  = req_valid && clk_en;
  assign refused = rq_full;
  assign rq_push = accept && !rq_full;
  assign rq_pop  = clk_en && !rq_empty && t_req_ready;

  cvt21_cxu_queue #(.W(REQ_W), .DEPTH(CXU_FIFO_SIZE)) u_req_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rq_push),
    .push_data ({req_func, req_state, req_cxu, req_data0, req_data1}),
    .pop       (rq_pop),
    .head      (rq_head),
    .full      (rq_full),
    .empty     (rq_empty)
  );

  assign t_req_valid = !rq_empty;
  assign t_req_insn  = '0;
  assign {t_req_func, t_req_state, t_req_cxu, t_req_data0, t_req_data1} = rq_head;

  assign tap_valid   = dl_valid_q[CXU_LATENCY-1];
  assign tap_refused = dl_refused_q[CXU_LATENCY-1];
  assign rs_pop      = clk_en && tap_valid && !tap_refused && !rs_empty;
  assign miss        = clk_en && tap_valid && !tap_refused && rs_empty;

  // A response landing in the same cycle as its own miss must be dropped too,
  // otherwise the response queue would hold an answer nobody waits for.
  assign t_resp_ready = !rs_full;
  assign tresp_hs     = clk_en && t_resp_valid && !rs_full;
  assign discard      = tresp_hs && ((owed_q != '0) || miss);
  assign rs_push      = tresp_hs && !discard;

  cvt21_cxu_queue #(.W(RSP_W), .DEPTH(CXU_FIFO_SIZE)) u_rsp_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rs_push),
    .push_data ({t_resp_status, t_resp_data}),
    .pop       (rs_pop),
    .head      (rs_head),
    .full      (rs_full),
    .empty     (rs_empty)
  );

  always_comb begin
    dl_valid_d   = dl_valid_q;
    dl_refused_d = dl_refused_q;
    owed_d       = owed_q;
    if (clk_en) begin
      for (int i = CXU_LATENCY - 1; i > 0; i--) begin
        dl_valid_d[i]   = dl_valid_q[i-1];
        dl_refused_d[i] = dl_refused_q[i-1];
      end
      dl_valid_d[0]   = accept;
      dl_refused_d[0] = accept && refused;
    end
    // discard without owed can only coincide with miss, so the two cancel
    if (miss && !discard)      owed_d = owed_q + OWED_W'(1);
    else if (discard && !miss) owed_d = owed_q - OWED_W'(1);
  end

  always_comb begin
    resp_valid  = tap_valid;
    resp_status = '0;
    resp_data   = '0;
    if (tap_valid) begin
      if (!tap_refused && !rs_empty) {resp_status, resp_data} = rs_head;
      else                           resp_status = CXU_STATUS_ERROR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dl_valid_q   <= '0;
      dl_refused_q <= '0;
      owed_q       <= '0;
    end else begin
      dl_valid_q   <= dl_valid_d;
      dl_refused_q <= dl_refused_d;
      owed_q       <= owed_d;
    end
  end

endmodule

// File: tb/tb_cvt21_cxu.sv
module tb_cvt21_cxu;

  localparam int LAT  = 3;
  localparam int FIFO = 4;
  localparam logic [2:0] ST_ERR = 3'd1;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, req_valid;
  logic [0:0]  req_cxu, req_state;
  logic [9:0]  req_func;
  logic [31:0] req_data0, req_data1;
  logic        resp_valid;
  logic [2:0]  resp_status;
  logic [31:0] resp_data;
  logic        t_req_valid, t_req_ready;
  logic [0:0]  t_req_cxu, t_req_state, t_req_insn;
  logic [9:0]  t_req_func;
  logic [31:0] t_req_data0, t_req_data1;
  logic        t_resp_valid, t_resp_ready;
  logic [2:0]  t_resp_status;
  logic [31:0] t_resp_data;

  cvt21_cxu #(
    .CXU_N_CXUS(1), .CXU_N_STATES(1), .CXU_LATENCY(LAT), .CXU_FUNC_ID_W(10),
    .CXU_DATA_W(32), .CXU_INSN_W(0), .CXU_FIFO_SIZE(FIFO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req_valid(req_valid), .req_cxu(req_cxu), .req_state(req_state), .req_func(req_func),
    .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(resp_valid), .resp_status(resp_status), .resp_data(resp_data),
    .t_req_valid(t_req_valid), .t_req_ready(t_req_ready), .t_req_cxu(t_req_cxu),
    .t_req_state(t_req_state), .t_req_func(t_req_func), .t_req_insn(t_req_insn),
    .t_req_data0(t_req_data0), .t_req_data1(t_req_data1),
    .t_resp_valid(t_resp_valid), .t_resp_ready(t_resp_ready),
    .t_resp_status(t_resp_status), .t_resp_data(t_resp_data)
  );

  always #5 clk = ~clk;

  // Reference model: requests waiting for the target, deadlines in flight,
  // and the target's own pending responses. Response k answers request k.
  typedef struct {logic [11:0] hdr; logic [31:0] d0; logic [31:0] d1; int k;} rq_t;
  typedef struct {int due; bit refd; int k;} dl_t;
  typedef struct {int k; int due; logic [2:0] st; logic [31:0] data;} tg_t;

  rq_t mq[$];
  dl_t dl[$];
  tg_t tg[$];
  bit          arrived [8192];
  bit          missed  [8192];
  logic [34:0] rdata   [8192];

  int tick, nk, owed_exp;
  int n_chk, n_err;
  int p_req, p_en, p_rdy, maxd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, got, exp, tick);
    end
  endtask

  task automatic check_outputs();
    bit exp_v;
    exp_v = (dl.size() > 0) && (dl[0].due == tick);
    chk("resp_valid", 64'(resp_valid), 64'(exp_v));
    if (exp_v) begin
      if (dl[0].refd || !arrived[dl[0].k]) begin
        chk("resp_status_err", 64'(resp_status), 64'(ST_ERR));
        chk("resp_data_err", 64'(resp_data), 64'd0);
      end else begin
        chk("resp_status", 64'(resp_status), 64'(rdata[dl[0].k][34:32]));
        chk("resp_data", 64'(resp_data), 64'(rdata[dl[0].k][31:0]));
      end
    end
    chk("t_req_valid", 64'(t_req_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("t_req_hdr", 64'({t_req_func, t_req_state, t_req_cxu}), 64'(mq[0].hdr));
      chk("t_req_data0", 64'(t_req_data0), 64'(mq[0].d0));
      chk("t_req_data1", 64'(t_req_data1), 64'(mq[0].d1));
    end
    chk("t_req_insn", 64'(t_req_insn), 64'd0);
    chk("t_resp_ready", 64'(t_resp_ready), 64'd1);
    chk("owed", 64'(dut.owed_q), 64'(owed_exp));
  endtask

  task automatic step();
    bit  en, acc, refd, rq_hs, rs_hs, pop_dl;
    rq_t r;
    dl_t e;
    tg_t t;
    @(negedge clk);
    req_valid = ($urandom_range(99) < p_req);
    req_func  = 10'($urandom);
    req_state = 1'($urandom);
    req_cxu   = 1'($urandom);
    req_data0 = $urandom;
    req_data1 = $urandom;
    clk_en      = ($urandom_range(99) < p_en);
    t_req_ready = ($urandom_range(99) < p_rdy);
    if (tg.size() > 0 && tg[0].due <= tick) begin
      t_resp_valid  = 1'b1;
      t_resp_status = tg[0].st;
      t_resp_data   = tg[0].data;
    end else begin
      t_resp_valid  = 1'b0;
      t_resp_status = 3'($urandom);
      t_resp_data   = $urandom;
    end
    #1;
    check_outputs();
    en     = clk_en && rst_n;
    acc    = en && req_valid;
    refd   = acc && (mq.size() == FIFO);
    rq_hs  = en && (mq.size() > 0) && t_req_ready;
    rs_hs  = en && t_resp_valid && t_resp_ready;
    pop_dl = en && (dl.size() > 0) && (dl[0].due == tick);
    r.hdr = {req_func, req_state, req_cxu};
    r.d0  = req_data0;
    r.d1  = req_data1;
    r.k   = nk;
    @(posedge clk);
    if (en) tick++;
    if (pop_dl) begin
      e = dl.pop_front();
      if (!e.refd && !arrived[e.k]) begin
        missed[e.k] = 1'b1;
        owed_exp++;
      end
    end
    if (rs_hs) begin
      t = tg.pop_front();
      arrived[t.k] = 1'b1;
      rdata[t.k]   = {t.st, t.data};
      if (missed[t.k]) owed_exp--;
    end
    if (rq_hs) begin
      t.k    = mq[0].k;
      t.due  = tick + $urandom_range(maxd);
      t.st   = ($urandom_range(9) == 0) ? 3'($urandom) : 3'd0;
      t.data = $urandom;
      void'(mq.pop_front());
      tg.push_back(t);
    end
    if (acc) begin
      e.due  = tick + LAT - 1;
      e.refd = refd;
      e.k    = nk;
      if (!refd) begin
        mq.push_back(r);
        nk++;
      end
      dl.push_back(e);
    end
  endtask

  task automatic run(input int n, input int preq, input int pen, input int prdy, input int md);
    p_req = preq; p_en = pen; p_rdy = prdy; maxd = md;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    clk_en    = 1'($urandom);
    req_valid = 1'b1;
    t_resp_valid = (tg.size() > 0);
    repeat (2) @(posedge clk);
    mq.delete();
    dl.delete();
    tg.delete();
    owed_exp = 0;
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_status", 64'(resp_status), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_t_req_valid", 64'(t_req_valid), 64'd0);
    chk("rst_t_resp_ready", 64'(t_resp_ready), 64'd1);
    chk("rst_owed", 64'(dut.owed_q), 64'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    clk_en       = 1'b0;
    req_valid    = 1'b0;
    t_resp_valid = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_err = 0; tick = 0; nk = 0; owed_exp = 0;
    rst_n = 1'b0; clk_en = 1'b0; req_valid = 1'b0;
    req_cxu = '0; req_state = '0; req_func = '0; req_data0 = '0; req_data1 = '0;
    t_req_ready = 1'b0; t_resp_valid = 1'b0; t_resp_status = '0; t_resp_data = '0;
    do_reset();
    run(300, 60, 100, 100, 0);  // fast target: every deadline met
    run(400, 50, 100, 70, 4);   // slow target: misses, owed, discards
    run(200, 90, 100, 5, 2);    // stalled target: request queue fills, refusals
    run(400, 50, 50, 80, 1);    // clk_en toggling
    run(30, 80, 100, 90, 3);
    do_reset();                 // reset with work in flight
    run(400, 60, 80, 75, 3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
